interleaver_bus_param: RTL and testbench

- Parametrised successor of the fixed 8-lane interleaver bus.
- Buffers one CRC-delimited block of LANES-bit words and replays it in row/column-interleaved order.
- Pruning skips padding positions, so any block length from 1 to DEPTH is legal.
- A runtime mode selects a per-lane bit-offset pattern, and the output has a valid/ready handshake with backpressure.

---
 rtl/interleaver_bus_param_if.sv | 28 ++
 rtl/interleaver_bus_param.sv | 171 +++++++++++++++++
 tb/tb_interleaver_bus_param.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/interleaver_bus_param_if.sv
// Block-control, input-stream and output-handshake signals of the parametrised interleaver.
// The master drives block control, input words and out_ready; the slave is the interleaver.
interface interleaver_bus_param_if #(
  parameter int LANES = 8,
  parameter int AW    = 6
);
  logic             CRC_start;
  logic             CRC_end;
  logic [AW:0]      blk_len;
  logic [1:0]       mode;
  logic             in_valid;
  logic [LANES-1:0] data_in;
  logic             out_ready;
  logic [LANES-1:0] data_out;
  logic             data_ready;
  logic             busy;
  logic             done;

  modport master (
    output CRC_start, CRC_end, blk_len, mode, in_valid, data_in, out_ready,
    input  data_out, data_ready, busy, done
  );

  modport slave (
    input  CRC_start, CRC_end, blk_len, mode, in_valid, data_in, out_ready,
    output data_out, data_ready, busy, done
  );
endinterface

// File: rtl/interleaver_bus_param.sv
// Buffers one block of LANES-bit words and replays it column-by-column with padding
// positions pruned, applying a per-lane bit permutation on the way out.
module interleaver_bus_param #(
  parameter int LANES = 8,
  parameter int DEPTH = 64,
  parameter int ROWS  = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  interleaver_bus_param_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_DRAIN,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam logic [AW:0] ONE     = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] ROWS_W  = (AW+1)'(ROWS);

  state_t           r_state, w_state_next;
  logic [AW:0]      r_k, r_wr_cnt, r_c, r_col, r_row, r_addr;
  logic [1:0]       r_mode;
  logic [LANES-1:0] r_mem [DEPTH];
  logic [LANES-1:0] r_rd_data;
  logic             r_rd_valid;
  logic [LANES-1:0] r_data_out;
  logic             r_data_ready;

  logic [AW:0] w_k_next, w_k_start, w_k_end, w_c_next;
  logic [AW:0] w_wr_cnt_inc, w_next_addr, w_next_row, w_col_inc;
  logic        w_enter_drain, w_wr_en, w_advance, w_issue, w_col_end, w_last_issue;
  logic        w_busy, w_done;

  function automatic logic [LANES-1:0] lane_permute(input logic [LANES-1:0] w,
                                                    input logic [1:0]       m);
    logic [LANES-1:0] p;
    p = w;
    for (int j = 0; j < LANES; j++) begin
      case (m)
        2'd1:    p[j] = (j % 2 == 1) ? w[(j + 2) % LANES] : w[j];
        2'd2:    p[j] = w[(LANES - j) % LANES];
        default: p[j] = w[j];
      endcase
    end
    return p;
  endfunction

  assign w_k_start    = (bus.blk_len > DEPTH_W) ? DEPTH_W : bus.blk_len;
  assign w_k_end      = r_wr_cnt + {{AW{1'b0}}, bus.in_valid};
  assign w_wr_cnt_inc = r_wr_cnt + ONE;
  assign w_wr_en      = (r_state == S_FILL) && bus.in_valid;
  assign w_c_next     = (w_k_next + ROWS_W - ONE) / ROWS_W;

  // The read/output pipeline moves only when the output register can take a new word.
  assign w_advance    = !r_data_ready || bus.out_ready;
  assign w_issue      = (r_state == S_DRAIN) && w_advance;
  assign w_next_addr  = r_addr + r_c;
  assign w_next_row   = r_row + ONE;
  assign w_col_inc    = r_col + ONE;
  // Addresses grow down a column, so the first padding hit ends the column at no cost.
  assign w_col_end    = (w_next_row == ROWS_W) || (w_next_addr >= r_k);
  assign w_last_issue = w_issue && w_col_end && (w_col_inc == r_c);

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: defaults come first so no branch leaves a signal unassigned and infers a latch.
    w_state_next  = r_state;
    w_k_next      = r_k;
    w_enter_drain = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.CRC_start) begin
          w_k_next     = w_k_start;
          w_state_next = (w_k_start == '0) ? S_DONE : S_FILL;
        end
      end
      S_FILL: begin
        if (bus.CRC_end) begin
          w_k_next = w_k_end;
          if (w_k_end == '0) begin
            w_state_next = S_DONE;
          end else begin
            w_state_next  = S_DRAIN;
            w_enter_drain = 1'b1;
          end
        end else if (bus.in_valid && (w_wr_cnt_inc == r_k)) begin
          w_state_next  = S_DRAIN;
          w_enter_drain = 1'b1;
        end
      end
      S_DRAIN: begin
        if (w_last_issue) w_state_next = S_FLUSH;
      end
      S_FLUSH: begin
        if (r_data_ready && bus.out_ready && !r_rd_valid) w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    w_busy = (r_state != S_IDLE);
    w_done = (r_state == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_k          <= '0;
      r_mode       <= '0;
      r_wr_cnt     <= '0;
      r_c          <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_addr       <= '0;
      r_rd_valid   <= 1'b0;
      r_data_out   <= '0;
      r_data_ready <= 1'b0;
    end else begin
      r_k <= w_k_next;
      if ((r_state == S_IDLE) && bus.CRC_start) begin
        r_mode   <= bus.mode;
        r_wr_cnt <= '0;
      end else if (w_wr_en) begin
        r_wr_cnt <= w_wr_cnt_inc;
      end

      if (w_enter_drain) begin
        r_c    <= w_c_next;
        r_col  <= '0;
        r_row  <= '0;
        r_addr <= '0;
      end else if (w_issue) begin
        if (w_col_end) begin
          r_col  <= w_col_inc;
          r_row  <= '0;
          r_addr <= w_col_inc;
        end else begin
          r_row  <= w_next_row;
          r_addr <= w_next_addr;
        end
      end

      if (w_advance) begin
        r_data_ready <= r_rd_valid;
        if (r_rd_valid) r_data_out <= lane_permute(r_rd_data, r_mode);
        r_rd_valid <= w_issue;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; its contents are only read after being written.
    if (w_wr_en) r_mem[r_wr_cnt[AW-1:0]] <= bus.data_in;
    if (w_issue) r_rd_data <= r_mem[r_addr[AW-1:0]];
  end

  assign bus.data_out   = r_data_out;
  assign bus.data_ready = r_data_ready;
  assign bus.busy       = w_busy;
  assign bus.done       = w_done;

endmodule

// File: tb/tb_interleaver_bus_param.sv
// Scoreboard bench for interleaver_bus_param: directed cases plus randomized blocks
// checked against an index-arithmetic reference of the interleaved, lane-permuted order.
module tb_interleaver_bus_param;
  localparam int LANES = 8;
  localparam int DEPTH = 64;
  localparam int ROWS  = 4;
  localparam int AW    = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  interleaver_bus_param_if #(.LANES(LANES), .AW(AW)) bus ();

  interleaver_bus_param #(.LANES(LANES), .DEPTH(DEPTH), .ROWS(ROWS), .AW(AW)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int             n_checks = 0;
  int             n_fail   = 0;
  int             done_cnt = 0;
  int             rdy_mode = 0;
  logic [7:0]     exp_q[$];
  logic [7:0]     blk_data[DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: output lane j takes bit src_lane(j) of the stored word.
  function automatic int src_lane(input int j, input logic [1:0] m);
    case (m)
      2'd1:    return (j % 2 == 1) ? (j + 2) % LANES : j;
      2'd2:    return (LANES - j) % LANES;
      default: return j;
    endcase
  endfunction

  function automatic logic [7:0] lane_map(input logic [7:0] w, input logic [1:0] m);
    logic [7:0] r;
    for (int j = 0; j < LANES; j++) r[j] = w[src_lane(j, m)];
    return r;
  endfunction

  task automatic model_push(input int k, input logic [1:0] m);
    int c_cols;
    c_cols = (k + ROWS - 1) / ROWS;
    for (int c = 0; c < c_cols; c++)
      for (int r = 0; r < ROWS; r++)
        if (r * c_cols + c < k) exp_q.push_back(lane_map(blk_data[r * c_cols + c], m));
  endtask

  // Monitor: pops on every accepted word and checks that stalled outputs hold.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    logic [7:0] exp_w;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (bus.done) done_cnt++;
        if (prev_stall) begin
          check("stall_hold_valid", 32'(bus.data_ready), 32'd1);
          check("stall_hold_data", 32'(bus.data_out), 32'(prev_data));
        end
        if (bus.data_ready && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word: got 0x%0h expected no word at %0t", bus.data_out, $time);
          end else begin
            exp_w = exp_q.pop_front();
            check("data_out", 32'(bus.data_out), 32'(exp_w));
          end
        end
        prev_stall = bus.data_ready && !bus.out_ready;
        prev_data  = bus.data_out;
      end
    end
  end

  // Backpressure generator: 0 always ready, 1 pattern 1,0,0,1, 2 random, 3 never.
  initial begin
    int ph;
    ph = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (ph % 4 == 0) || (ph % 4 == 3);
        2:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
      ph++;
    end
  end

  task automatic start_block(input int len, input logic [1:0] m);
    @(posedge clk);
    #1;
    bus.CRC_start = 1'b1;
    bus.blk_len   = 7'(len);
    bus.mode      = m;
    @(posedge clk);
    #1;
    bus.CRC_start = 1'b0;
    bus.blk_len   = 7'($urandom);
    bus.mode      = 2'($urandom);
  endtask

  task automatic feed(input int n, input int end_at, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        @(posedge clk);
        #1;
      end
      bus.in_valid = 1'b1;
      bus.data_in  = blk_data[i];
      bus.CRC_end  = (i == end_at);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.CRC_end  = 1'b0;
      bus.data_in  = 8'($urandom);
    end
  endtask

  task automatic wait_done(input string name, input int d0);
    int cyc;
    for (cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      #1;
      if (done_cnt != d0) break;
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    check({name, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    check({name, "_busy_low"}, 32'(bus.busy), 32'd0);
    check({name, "_no_extra_valid"}, 32'(bus.data_ready), 32'd0);
    check({name, "_words_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic fill_ramp(input int base);
    for (int i = 0; i < DEPTH; i++) blk_data[i] = 8'(base + i);
  endtask

  initial begin
    int d0, len, k, end_at;
    logic [1:0] m;
    bus.CRC_start = 1'b0;
    bus.CRC_end   = 1'b0;
    bus.blk_len   = '0;
    bus.mode      = '0;
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;

    #12;
    check("reset_data_out", 32'(bus.data_out), 32'd0);
    check("reset_data_ready", 32'(bus.data_ready), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // K=8, mode 0, full rate.
    fill_ramp(0);
    exp_q = {8'h00, 8'h02, 8'h04, 8'h06, 8'h01, 8'h03, 8'h05, 8'h07};
    d0 = done_cnt;
    start_block(8, 2'd0);
    feed(8, -1, 1'b0);
    wait_done("k8", d0);

    // K=6: addresses 6 and 7 pruned.
    exp_q = {8'h00, 8'h02, 8'h04, 8'h01, 8'h03, 8'h05};
    d0 = done_cnt;
    start_block(6, 2'd0);
    feed(6, -1, 1'b0);
    wait_done("k6", d0);

    // Single-word blocks exercising each lane mode.
    blk_data[0] = 8'h02; exp_q = {8'h80}; d0 = done_cnt;
    start_block(1, 2'd2); feed(1, -1, 1'b0); wait_done("k1_mode2", d0);
    blk_data[0] = 8'h02; exp_q = {8'h80}; d0 = done_cnt;
    start_block(1, 2'd1); feed(1, -1, 1'b0); wait_done("k1_mode1a", d0);
    blk_data[0] = 8'h08; exp_q = {8'h02}; d0 = done_cnt;
    start_block(1, 2'd1); feed(1, -1, 1'b0); wait_done("k1_mode1b", d0);
    blk_data[0] = 8'h5A; exp_q = {8'h5A}; d0 = done_cnt;
    start_block(1, 2'd0); feed(1, -1, 1'b0); wait_done("k1_mode0", d0);

    // K=8 under 1,0,0,1 backpressure.
    fill_ramp(0);
    rdy_mode = 1;
    exp_q = {8'h00, 8'h02, 8'h04, 8'h06, 8'h01, 8'h03, 8'h05, 8'h07};
    d0 = done_cnt;
    start_block(8, 2'd0);
    feed(8, -1, 1'b0);
    wait_done("k8_stall", d0);
    rdy_mode = 0;

    // CRC_end on the 5th word truncates to K=5; CRC_start mid-drain is ignored.
    exp_q = {8'h00, 8'h02, 8'h04, 8'h01, 8'h03};
    d0 = done_cnt;
    start_block(8, 2'd0);
    feed(8, 4, 1'b0);
    check("drain_busy", 32'(bus.busy), 32'd1);
    bus.CRC_start = 1'b1;
    bus.blk_len   = 7'd3;
    bus.mode      = 2'd2;
    @(posedge clk);
    #1;
    bus.CRC_start = 1'b0;
    wait_done("crc_end_k5", d0);

    // blk_len=0 completes without output.
    d0 = done_cnt;
    start_block(0, 2'd0);
    wait_done("k0", d0);

    // Reset in the middle of DRAIN while the output is stalled.
    fill_ramp(8'hA0);
    rdy_mode = 3;
    d0 = done_cnt;
    start_block(8, 2'd0);
    feed(8, -1, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midreset_data_out", 32'(bus.data_out), 32'd0);
    check("midreset_data_ready", 32'(bus.data_ready), 32'd0);
    check("midreset_busy", 32'(bus.busy), 32'd0);
    check("midreset_done", 32'(bus.done), 32'd0);
    exp_q.delete();
    rdy_mode = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("midreset_no_done", 32'(done_cnt - d0), 32'd0);

    fill_ramp(0);
    exp_q = {8'h00, 8'h01, 8'h02, 8'h03};
    d0 = done_cnt;
    start_block(4, 2'd0);
    feed(4, -1, 1'b0);
    wait_done("after_reset_k4", d0);

    // Randomized blocks against the reference model.
    for (int b = 0; b < 30; b++) begin
      for (int i = 0; i < DEPTH; i++) blk_data[i] = 8'($urandom);
      len      = $urandom_range(0, DEPTH + 6);
      m        = 2'($urandom);
      rdy_mode = $urandom_range(0, 2);
      k        = (len > DEPTH) ? DEPTH : len;
      end_at   = -1;
      if (k > 0 && $urandom_range(0, 3) == 0) begin
        end_at = $urandom_range(0, k - 1);
        k      = end_at + 1;
      end
      model_push(k, m);
      d0 = done_cnt;
      start_block(len, m);
      feed(k, end_at, 1'b1);
      wait_done("random_block", d0);
    end
    rdy_mode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
